gfx_bus_target: RTL
===================

# gfx_bus_target

Bus-side responder endpoint for one graphics device (D0–D3) on the switched SoC bus. Accepts a request that the bus switch forwards on the device's `selin`/`cmdin`/`addrdatain`/`lenin` inputs, performs single or 16-beat reads and writes against a local word register file, and returns the response. The response goes back through the switch using the device's `reqout`/`ackin` handshake and `addrdataout`/`cmdout`/`lenout` outputs. Display-pipeline logic reads the same register file through a private local read port.

## Interface
- `BASE_ADDR`, default 32'hF000_0000: byte base of the device window; D1–D3 instances use 0x100, 0x200 and 0x300 offsets.
- `DEPTH`, default 64: number of 32-bit words. Must be a power of two. Window size is DEPTH*4 bytes.
- `RESP_TAR`, default 4'hF: value driven on `reqtar` for every response.

- `clk`  in  1  bus clock; all state updates on the rising edge.
- `reset`  in  1  reset, asynchronous, active-high.
- `selin`  in  1  request/write-data beat valid from the switch.
- `cmdin`  in  3  command: READ=3'b001, WRITE=3'b010.
- `addrdatain`  in  32  byte address on the first beat; write data on later beats.
- `lenin`  in  2  length code: 3 = 16 beats, any other value = 1 beat.
- `ackin`  in  1  switch grant for the pending response.
- `reqout`  out  2  response request; bit0 is used, bit1 is tied to 0.
- `reqtar`  out  4  response target.
- `addrdataout`  out  32  response beat.
- `cmdout`  out  3  READ_RESP=3'b100, WRITE_ACK=3'b101, ERR=3'b111.
- `lenout`  out  2  response length code.
- `loc_idx`  in  log2(DEPTH)  local read word index.
- `loc_data`  out  32  local read data, registered.
- `err_sticky`  out  1  protocol-error flag. Present only with GFX_TGT_ERR_EN; otherwise tied to 0.

## Operation
- Reset values: every output is 0 (`reqtar` 0, `err_sticky` 0), state is IDLE, and all register-file words are 0.
- Word index = `addrdatain[2 +: log2(DEPTH)]`. An address is in window when `addr[31:log2(DEPTH)+2]` equals the same bits of BASE_ADDR.
- Beat count L is 16 when `lenin`==3, otherwise 1. `lenin` is captured on the first beat.
- IDLE:
  - `selin`=1 captures cmd, index, L and the start address.
  - WRITE goes to WDATA.
  - READ goes to RESP_REQ.
  - Any other cmd, or an out-of-window address, is handled as described in Configuration.
- WDATA:
  - Each cycle with `selin`=1 writes `addrdatain` to word[idx], then increments idx modulo DEPTH (wrap, no error).
  - A cycle with `selin`=0 stalls with no write.
  - After the L-th beat the block goes to RESP_REQ.
- RESP_REQ:
  - `reqout`=1 and `reqtar`=RESP_TAR are held until `ackin`=1 is sampled.
  - The block then moves to RESP_DATA and `reqout` returns to 0.
- RESP_DATA, read: L consecutive beats. Each beat drives `addrdataout`=word[idx] (idx increments modulo DEPTH), `cmdout`=READ_RESP and `lenout`=captured code.
- RESP_DATA, write: one beat with `addrdataout`=start address, `cmdout`=WRITE_ACK and `lenout`=0.
- After the last beat, outputs are zeroed and the block returns to IDLE.
- `selin` outside IDLE/WDATA is ignored. `ackin` outside RESP_REQ is ignored.
- A local read never stalls bus traffic. A same-cycle bus write to `loc_idx` returns the old value.
- Reset mid-transaction aborts immediately: the block returns to the reset state, and no partial response is driven.

## Timing
- Request accepted on cycle 0: `reqout` rises on cycle 1 for a read, or on cycle L+1+stalls for a write.
- `ackin` sampled high on cycle k:
  - first response beat on cycle k+1, with `reqout`=0 on the same cycle;
  - last beat on cycle k+L;
  - outputs are 0 and a new `selin` is accepted on cycle k+L+1.
- `loc_data` = word[`loc_idx`] one cycle after `loc_idx` is presented.

## Configuration
- `GFX_TGT_ERR_EN` defined:
  - an illegal cmd or out-of-window address on an IDLE `selin` skips any data phase;
  - the block responds with one ERR beat (`addrdataout`=offending address, `lenout`=0) via RESP_REQ;
  - `err_sticky` is set, and also set by `selin` seen in RESP_REQ/RESP_DATA;
  - `err_sticky` clears only on reset.
- Undefined: illegal requests are silently dropped and the block stays in IDLE. `err_sticky` is constant 0.

## Structure
- Package `gfx_bus_pkg` holds:
  - cmd localparams (READ, WRITE, READ_RESP, WRITE_ACK, ERR);
  - LEN_BURST=2'd3 and BURST_BEATS=16;
  - the state enum {IDLE, WDATA, RESP_REQ, RESP_DATA};
  - RESP_TAR_DEFAULT.
- Sub-module `gfx_tgt_regfile` contains the DEPTH×32 storage with one bus write port, one bus combinational read port, and the registered local read port.
- The FSM, counters and address capture live in `gfx_bus_target`.

## Test plan
- Single write then read:
  - WRITE to 0xF000_0010, data 0xDEAD_BEEF → `reqout` high, then after `ackin` one beat with WRITE_ACK and `addrdataout`=0xF000_0010.
  - READ of the same address → one beat with READ_RESP and 0xDEAD_BEEF.
- Burst wrap: 16-beat write at word 56 with data 0..15, then a 16-beat read at word 56 → returns 0..15, and words 0..7 hold 8..15.
- Handshake hold: delay `ackin` by 7 cycles → `reqout` stays 1 for all 7 cycles, the first beat appears exactly 1 cycle after `ackin`, and there is no beat before it.
- Write stall: drop `selin` for 3 cycles mid-burst → no writes during the gap, the stored data is contiguous, and the response is delayed by 3 cycles.
- Reset mid-response: assert `reset` on beat 5 of a read → all outputs 0 asynchronously, the next READ behaves normally, and the register file reads 0.
- With `GFX_TGT_ERR_EN`, READ to 0xF000_0400 → one ERR beat with `addrdataout`=0xF000_0400, and `err_sticky`=1.

Source files
------------

// File: rtl/gfx_bus_pkg.sv
// Shared definitions for the graphics bus target: command codes, burst
// length encoding, response target default and the FSM state type.
package gfx_bus_pkg;

    localparam logic [2:0] CMD_READ      = 3'b001;
    localparam logic [2:0] CMD_WRITE     = 3'b010;
    localparam logic [2:0] CMD_READ_RESP = 3'b100;
    localparam logic [2:0] CMD_WRITE_ACK = 3'b101;
    localparam logic [2:0] CMD_ERR       = 3'b111;

    localparam logic [1:0] LEN_BURST   = 2'd3;
    localparam int         BURST_BEATS = 16;

    localparam logic [3:0] RESP_TAR_DEFAULT = 4'hF;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WDATA     = 2'd1,
        RESP_REQ  = 2'd2,
        RESP_DATA = 2'd3
    } tgt_state_t;

endpackage

// File: rtl/gfx_tgt_regfile.sv
// DEPTH x 32 word store for the graphics bus target. One bus write port,
// one combinational bus read port and a registered local read port for the
// display pipeline. All words clear on reset.
module gfx_tgt_regfile #(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_idx,
    input  logic [31:0]   wr_data,
    input  logic [AW-1:0] rd_idx,
    output logic [31:0]   rd_data,
    input  logic [AW-1:0] loc_idx,
    output logic [31:0]   loc_data
);

    logic [31:0] mem [DEPTH];

    // Bus write port; storage clears on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 32'h0;
            end
        end else if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    assign rd_data = mem[rd_idx];

    // Local read port: registered, so a same-cycle write returns the old word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            loc_data <= 32'h0;
        end else begin
            loc_data <= mem[loc_idx];
        end
    end

endmodule

// File: rtl/gfx_bus_target.sv
// Bus-side responder for one graphics device. Accepts single or 16-beat
// reads/writes from the switch, answers through the reqout/ackin handshake,
// and exposes a private local read port into the register file.
// Build option: GFX_TGT_ERR_EN enables ERR responses and err_sticky;
// without it illegal requests are dropped and err_sticky is tied low.
// Handshake: a response is offered by holding reqout[0]=1 in RESP_REQ until
// ackin is sampled high; beats then follow back-to-back, one per clock, and
// selin is only honoured in IDLE (request) and WDATA (write data beats).
module gfx_bus_target
    import gfx_bus_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'hF000_0000,
    parameter int          DEPTH     = 64,
    parameter logic [3:0]  RESP_TAR  = RESP_TAR_DEFAULT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     selin,
    input  logic [2:0]               cmdin,
    input  logic [31:0]              addrdatain,
    input  logic [1:0]               lenin,
    input  logic                     ackin,
    output logic [1:0]               reqout,
    output logic [3:0]               reqtar,
    output logic [31:0]              addrdataout,
    output logic [2:0]               cmdout,
    output logic [1:0]               lenout,
    input  logic [$clog2(DEPTH)-1:0] loc_idx,
    output logic [31:0]              loc_data,
    output logic                     err_sticky,
    output logic [1:0]               dbg_state
);

    localparam int AW = $clog2(DEPTH);

    tgt_state_t    state_q, state_d;
    logic [AW-1:0] idx_q;
    logic [3:0]    cnt_q;
    logic [1:0]    len_q;
    logic          burst_q;
    logic [2:0]    rcmd_q;
    logic [31:0]   addr_q;

    logic          wr_en;
    logic [31:0]   rd_data;
    logic          in_window, req_read, req_write, cnt_last, is_read_resp;

    assign in_window    = (addrdatain[31:AW+2] == BASE_ADDR[31:AW+2]);
    assign req_read     = in_window && (cmdin == CMD_READ);
    assign req_write    = in_window && (cmdin == CMD_WRITE);
    assign cnt_last     = burst_q ? (cnt_q == 4'(BURST_BEATS - 1)) : 1'b1;
    assign is_read_resp = (rcmd_q == CMD_READ_RESP);
    assign dbg_state    = state_q;

    gfx_tgt_regfile #(.DEPTH(DEPTH), .AW(AW)) u_regfile (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_idx   (idx_q),
        .wr_data  (addrdatain),
        .rd_idx   (idx_q),
        .rd_data  (rd_data),
        .loc_idx  (loc_idx),
        .loc_data (loc_data)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and Moore outputs; everything idles at zero.
    always_comb begin
        state_d     = state_q;
        wr_en       = 1'b0;
        reqout      = 2'b00;
        reqtar      = 4'h0;
        addrdataout = 32'h0;
        cmdout      = 3'b000;
        lenout      = 2'b00;
        case (state_q)
            IDLE: begin
                if (selin) begin
                    if (req_write) begin
                        state_d = WDATA;
                    end else if (req_read) begin
                        state_d = RESP_REQ;
                    end
`ifdef GFX_TGT_ERR_EN
                    else begin
                        state_d = RESP_REQ;
                    end
`endif
                end
            end
            WDATA: begin
                wr_en = selin;
                if (selin && cnt_last) begin
                    state_d = RESP_REQ;
                end
            end
            RESP_REQ: begin
                reqout = 2'b01;
                reqtar = RESP_TAR;
                if (ackin) begin
                    state_d = RESP_DATA;
                end
            end
            RESP_DATA: begin
                reqtar = RESP_TAR;
                cmdout = rcmd_q;
                if (is_read_resp) begin
                    addrdataout = rd_data;
                    lenout      = len_q;
                end else begin
                    addrdataout = addr_q;
                end
                if (!is_read_resp || cnt_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Request capture, word index and beat counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_q   <= '0;
            cnt_q   <= 4'd0;
            len_q   <= 2'b00;
            burst_q <= 1'b0;
            rcmd_q  <= 3'b000;
            addr_q  <= 32'h0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (selin) begin
                        addr_q  <= addrdatain;
                        idx_q   <= addrdatain[2 +: AW];
                        len_q   <= lenin;
                        burst_q <= (lenin == LEN_BURST);
                        cnt_q   <= 4'd0;
                        rcmd_q  <= req_write ? CMD_WRITE_ACK :
                                   req_read  ? CMD_READ_RESP : CMD_ERR;
                    end
                end
                WDATA: begin
                    if (selin) begin
                        idx_q <= idx_q + 1'b1;
                        cnt_q <= cnt_last ? 4'd0 : cnt_q + 4'd1;
                    end
                end
                RESP_DATA: begin
                    idx_q <= idx_q + 1'b1;
                    cnt_q <= cnt_q + 4'd1;
                end
                default: ;
            endcase
        end
    end

`ifdef GFX_TGT_ERR_EN
    logic err_q;

    // Sticky protocol error: illegal request, or selin while a response is pending.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (selin && (((state_q == IDLE) && !req_read && !req_write) ||
                               (state_q == RESP_REQ) || (state_q == RESP_DATA))) begin
            err_q <= 1'b1;
        end
    end

    assign err_sticky = err_q;
`else
    assign err_sticky = 1'b0;
`endif

endmodule
